// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
// Shares the single CPU-side cache port between the instruction-fetch side (I)
// and the data side (D). One transfer is in flight at a time. A grant cycle in
// IDLE loads the cpu_req_* registers. BUSY then holds them until the cache
// returns its one-cycle cpu_ready pulse, which also acks the owning side.
//
// Configuration macro ARB_RR_EN:
//   defined   - simultaneous requests are granted round-robin against last-grant
//   undefined - fixed priority, the data side always wins
module cache_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stop,
  // data requester
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stop,
  // cache CPU-side port
  output logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_rw,
  output logic              cpu_req_valid,
  output logic [DATA_W-1:0] cpu_data_write,
  input  logic [DATA_W-1:0] cpu_data_read,
  input  logic              cpu_ready
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  state_e            state;
  owner_e            owner;
  logic              last_d;   // last completed grant went to D (0 = I)
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic ack_i;
  logic ack_d;

  assign i_req = i_re;
  assign d_req = d_re | d_we;

  // Winner selection for a grant taken in IDLE.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant_d = 1'b0;
`ifdef ARB_RR_EN
    // On a tie, grant the side that did not complete the previous transfer.
    grant_d = d_req & (~i_req | ~last_d);
`else
    grant_d = d_req;
`endif
  end

`ifndef ARB_RR_EN
  // Last-grant is tracked in both builds; fixed priority simply ignores it.
  logic unused_last_grant;
  assign unused_last_grant = last_d;
`endif

  // Completion strobes: the cache's ready pulse acks whoever owns the port.
  assign ack_i = (state == ST_BUSY) && (owner == OWN_I) && cpu_ready;
  assign ack_d = (state == ST_BUSY) && (owner == OWN_D) && cpu_ready;

  // Stalls and read data returned to the requesters.
  // Read data bypasses the hold register on the ack cycle.
  always_comb begin
    i_stop  = i_req & ~ack_i;
    d_stop  = d_req & ~ack_d;
    i_rdata = ack_i ? cpu_data_read : i_hold;
    d_rdata = (ack_d && !cpu_req_rw) ? cpu_data_read : d_hold;
  end

  // Transfer sequencer: grant in IDLE, hold the request in BUSY until ready.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      owner          <= OWN_NONE;
      last_d         <= 1'b0;
      cpu_req_valid  <= 1'b0;
      cpu_req_rw     <= 1'b0;
      cpu_req_addr   <= '0;
      cpu_data_write <= '0;
      i_hold         <= '0;
      d_hold         <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // Valid is always low here, so the cache never sees back-to-back valid.
          if (i_req || d_req) begin
            state          <= ST_BUSY;
            owner          <= grant_d ? OWN_D : OWN_I;
            cpu_req_valid  <= 1'b1;
            cpu_req_addr   <= grant_d ? d_addr : i_addr;
            cpu_req_rw     <= grant_d & d_we;
            cpu_data_write <= grant_d ? d_wdata : '0;
          end
        end
        ST_BUSY: begin
          if (cpu_ready) begin
            state         <= ST_IDLE;
            owner         <= OWN_NONE;
            cpu_req_valid <= 1'b0;
            last_d        <= (owner == OWN_D);
            if (ack_i) begin
              i_hold <= cpu_data_read;
            end
            if (ack_d && !cpu_req_rw) begin
              d_hold <= cpu_data_read;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter
// Random and directed stimulus for cache_port_arbiter. A transfer-level
// reference model predicts the stalls, read data and cache request.
// The model tracks: one transfer outstanding or not, who owns it, what was
// requested, and the last value each side got back.
module tb_cache_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_re;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stop;
  logic              d_re;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stop;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_rw;
  logic              cpu_req_valid;
  logic [DATA_W-1:0] cpu_data_write;
  logic [DATA_W-1:0] cpu_data_read;
  logic              cpu_ready;

  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_re           (i_re),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_stop         (i_stop),
    .d_re           (d_re),
    .d_we           (d_we),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_stop         (d_stop),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_rw     (cpu_req_rw),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_data_write (cpu_data_write),
    .cpu_data_read  (cpu_data_read),
    .cpu_ready      (cpu_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit                m_busy;
  bit                m_own_d;
  bit                m_last_d;
  logic [ADDR_W-1:0] m_addr;
  bit                m_rw;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_hold_i;
  logic [DATA_W-1:0] m_hold_d;
  int                m_k;        // cycles the current transfer has been valid
  int                c_lat;      // cycle of valid on which the cache answers
  int                fixed_lat;  // 0 = random latency per transfer
  bit                spur_en;    // allow stray ready pulses while idle
  logic [DATA_W-1:0] c_data;
  bit                ack_i_seen;
  bit                ack_d_seen;
  bit                grants[$]; // 1 = D, in grant order

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_own_d  = 1'b0;
    m_last_d = 1'b0;
    m_hold_i = '0;
    m_hold_d = '0;
    m_k      = 0;
  endtask

  // One clock cycle. Called just after a falling edge with requests already
  // driven; returns at the next falling edge. Acked requests are dropped.
  task automatic step();
    bit i_req, d_req, ai, ad, win_d;
    cpu_ready     = (m_busy && m_k == c_lat) ||
                    (!m_busy && spur_en && $urandom_range(3) == 0);
    cpu_data_read = c_data;
    #1;
    i_req = i_re;
    d_req = d_re | d_we;
    ai = m_busy && !m_own_d && cpu_ready;
    ad = m_busy &&  m_own_d && cpu_ready;
    check("valid",  cpu_req_valid, m_busy);
    check("i_stop", i_stop, i_req && !ai);
    check("d_stop", d_stop, d_req && !ad);
    check("i_rdata", i_rdata, ai ? c_data : m_hold_i);
    check("d_rdata", d_rdata, (ad && !m_rw) ? c_data : m_hold_d);
    if (m_busy) begin
      check("addr", cpu_req_addr, m_addr);
      check("rw",   cpu_req_rw, m_rw);
      if (m_rw) check("wdata", cpu_data_write, m_wdata);
    end
    ack_i_seen = ai;
    ack_d_seen = ad;
    if (m_busy) begin
      if (cpu_ready) begin
        if (ai) m_hold_i = c_data;
        if (ad && !m_rw) m_hold_d = c_data;
        m_last_d = m_own_d;
        m_busy   = 1'b0;
      end else begin
        m_k++;
      end
    end else if (i_req || d_req) begin
`ifdef ARB_RR_EN
      win_d = (i_req && d_req) ? !m_last_d : d_req;
`else
      win_d = d_req;
`endif
      grants.push_back(win_d);
      m_busy  = 1'b1;
      m_own_d = win_d;
      m_addr  = win_d ? d_addr : i_addr;
      m_rw    = win_d && d_we;
      m_wdata = d_wdata;
      m_k     = 1;
      c_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
    end
    @(negedge clk);
    cpu_ready = 1'b0;
    if (ai) i_re = 1'b0;
    if (ad) begin
      d_re = 1'b0;
      d_we = 1'b0;
    end
  endtask

  // Step until the named side is acked; an expired budget counts as a failure.
  task automatic wait_ack(input bit side_d, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      step();
      got = side_d ? ack_d_seen : ack_i_seen;
    end
    check({tag, "_timeout"}, got, 1'b1);
  endtask

  initial begin
    int xfers;
    bit mark_d;
    i_re = 0; d_re = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    cpu_ready = 0; cpu_data_read = '0; c_data = '0;
    fixed_lat = 0; spur_en = 0;
    rst = 1'b0;
    model_reset();

    // reset held with random inputs
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      i_re = 1'($urandom); d_re = 1'($urandom); d_we = 1'($urandom);
      i_addr = 8'($urandom); d_addr = 8'($urandom); d_wdata = $urandom;
      cpu_ready = 1'($urandom); cpu_data_read = $urandom;
      #1;
      check("rst_valid", cpu_req_valid, 1'b0);
      check("rst_addr",  cpu_req_addr, '0);
      check("rst_rw",    cpu_req_rw, 1'b0);
      check("rst_wdata", cpu_data_write, '0);
      check("rst_i_rdata", i_rdata, '0);
      check("rst_d_rdata", d_rdata, '0);
    end
    @(negedge clk);
    i_re = 0; d_re = 0; d_we = 0; cpu_ready = 0;
    rst = 1'b1;

    // both sides requesting continuously for 6 transfers
    grants.delete();
    xfers = 0;
    for (int n = 0; n < 200 && xfers < 6; n++) begin
      if (!i_re) begin i_re = 1'b1; i_addr = 8'($urandom); end
      if (!d_re) begin d_re = 1'b1; d_addr = 8'($urandom); end
      c_data = $urandom;
      step();
      xfers += int'(ack_i_seen) + int'(ack_d_seen);
    end
    check("contend_xfers", xfers, 6);
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_RR_EN
      mark_d = (k % 2 == 0);
`else
      mark_d = 1'b1;
`endif
      check($sformatf("contend_grant%0d", k), (k < grants.size()) ? grants[k] : 1'bx, mark_d);
    end
    i_re = 0; d_re = 0;
    for (int n = 0; n < 8; n++) step();

    // lone fetch, cache answers on the 3rd cycle of valid
    fixed_lat = 3;
    i_re = 1'b1; i_addr = 8'h10; c_data = 32'hDEADBEEF;
    wait_ack(1'b0, "fetch");
    step();
    check("fetch_hold", i_rdata, 32'hDEADBEEF);

    // data write: d_rdata must not change
    d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h12345678; c_data = 32'hCAFEF00D;
    wait_ack(1'b1, "write");
    step();

    // simultaneous fetch and data read from IDLE
    fixed_lat = 2;
    i_re = 1'b1; i_addr = 8'h31; d_re = 1'b1; d_addr = 8'h42; c_data = 32'hA5A5_0001;
    grants.delete();
    for (int n = 0; n < 20 && (i_re || d_re); n++) begin
      if (ack_d_seen) c_data = 32'hA5A5_0002;
      step();
    end
    check("pair_count", grants.size(), 2);
    for (int n = 0; n < 3; n++) step();

    // async reset between edges while a transfer is outstanding
    fixed_lat = 4;
    d_re = 1'b1; d_addr = 8'h55;
    step(); step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid",  cpu_req_valid, 1'b0);
    check("arst_d_stop", d_stop, 1'b1);
    check("arst_i_stop", i_stop, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_ack(1'b1, "regrant");

    // randomized traffic with stray ready pulses in IDLE
    fixed_lat = 0;
    spur_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (!i_re && $urandom_range(1) == 1) begin
        i_re = 1'b1; i_addr = 8'($urandom);
      end
      if (!(d_re || d_we) && $urandom_range(1) == 1) begin
        case ($urandom_range(2))
          0:       begin d_re = 1'b1; d_we = 1'b0; end
          1:       begin d_re = 1'b0; d_we = 1'b1; end
          default: begin d_re = 1'b1; d_we = 1'b1; end
        endcase
        d_addr = 8'($urandom); d_wdata = $urandom;
      end
      c_data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
